// File: rtl/config_chain_loader.sv
// -----------------------------------------------------------------------------
// config_chain_loader
//
// Writer side of the fabric configuration interface. Bitstream words arrive on
// a valid/ready stream and are serialised LSB-first onto the config scan chain,
// one bit per clk. cset is held low while the chain is being written and rises
// in DONE, so the fabric only applies a completely loaded configuration.
//
// Optional feature macro: CFG_CHECKSUM_EN
//   When defined, after the last chain bit one extra word is accepted and
//   compared with the mod-2^WORD_W sum of all accepted data words. A mismatch
//   sets the sticky err flag and keeps cset low (done still pulses).
//   When undefined there is no CHECK state and err is tied to 0.
//
// Handshake: a word transfers on every rising clk edge where s_valid and
// s_ready are both 1. s_ready does not depend on s_valid. The source must hold
// s_data stable while s_valid is 1 and s_ready is 0.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   start        in   1-cycle pulse, begins a load (ignored unless idle)
//   s_data       in   bitstream word, LSB shifted first
//   s_valid      in   s_data valid
//   s_ready      out  loader accepts s_data this cycle
//   cfg_sout     out  serial config data to the chain head
//   cfg_shift    out  chain shift enable
//   cset         out  1 = fabric applies configuration
//   busy         out  load in progress (LOAD/SHIFT/CHECK)
//   done         out  1-cycle pulse at end of load
//   err          out  sticky checksum error
//   o_dbg_state  out  current FSM state (debug)
// -----------------------------------------------------------------------------
module config_chain_loader #(
  parameter int CHAIN_LEN = 44,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_sout,
  output logic              cfg_shift,
  output logic              cset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic              r_cset;
  logic              w_last_bit;
  logic              w_word_end;

`ifdef CFG_CHECKSUM_EN
  logic [WORD_W-1:0] r_sum;
  logic              r_err;
`endif

  // The chain ends partway through the final word; the count decides that,
  // so the unused upper bits of the last word are simply never shifted.
  assign w_last_bit = (r_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end = (r_bit == BIT_W'(WORD_W - 1));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)   w_next = S_LOAD;
      S_LOAD:  if (s_valid) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last_bit) begin
`ifdef CFG_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else if (w_word_end) begin
          w_next = S_LOAD;
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHECK: if (s_valid) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    s_ready   = 1'b0;
    cfg_shift = 1'b0;
    cfg_sout  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_SHIFT: begin
        cfg_shift = 1'b1;
        cfg_sout  = r_shreg[0];
        busy      = 1'b1;
      end
      S_CHECK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign cset        = r_cset;
  assign o_dbg_state = r_state;

`ifdef CFG_CHECKSUM_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_cset  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      r_sum   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_cset <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            r_sum  <= '0;
            r_err  <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            r_shreg <= s_data;
            r_bit   <= '0;
`ifdef CFG_CHECKSUM_EN
            // Full word is summed, including bits that never reach the chain.
            r_sum   <= r_sum + s_data;
`endif
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          r_bit   <= r_bit + BIT_W'(1);
`ifndef CFG_CHECKSUM_EN
          if (w_last_bit) r_cset <= 1'b1;
`endif
        end
`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          if (s_valid) begin
            if (s_data != r_sum) r_err  <= 1'b1;
            else                 r_cset <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
module tb_config_chain_loader;

  localparam int CHAIN_LEN = 44;
  localparam int WORD_W    = 8;
  localparam int NWORDS    = 6;
`ifdef CFG_CHECKSUM_EN
  localparam int LAT = 51;
`else
  localparam int LAT = 50;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, cfg_sout, cfg_shift, cset, busy, done, err;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_sout(cfg_sout), .cfg_shift(cfg_shift), .cset(cset),
    .busy(busy), .done(done), .err(err), .o_dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int                   total = 0;
  int                   bad = 0;
  logic [0:0]           exp_q[$];
  logic [0:0]           exp_bit;
  logic [7:0]           words[NWORDS];
  logic [CHAIN_LEN-1:0] cap = '0;
  int                   n_shift = 0;
  logic                 m_cset = 1'b0;
  logic                 exp_good = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

`ifdef CFG_CHECKSUM_EN
  function automatic logic [7:0] model_sum();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < NWORDS; i++) s = s + words[i];
    return s;
  endfunction
`endif

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rst) begin
      n_shift = 0;
      m_cset  = 1'b0;
    end else begin
      if (cfg_shift) begin
        if (exp_q.size() == 0) begin
          check("extra_shift", 1, 0);
        end else begin
          exp_bit = exp_q.pop_front();
          check("sout_bit", cfg_sout, exp_bit);
        end
        if (n_shift < CHAIN_LEN) cap[n_shift] = cfg_sout;
        n_shift++;
        check("ready_in_shift", s_ready, 0);
      end
      if (busy) begin
        m_cset = 1'b0;
        check("cset_while_busy", cset, 0);
        check("done_while_busy", done, 0);
`ifdef CFG_CHECKSUM_EN
        check("err_while_busy", err, 0);
`endif
      end else if (done) begin
        check("done_nshift", n_shift, CHAIN_LEN);
        check("done_q_empty", exp_q.size(), 0);
        check("done_cset", cset, exp_good);
`ifdef CFG_CHECKSUM_EN
        check("done_err", err, !exp_good);
`endif
        m_cset  = exp_good;
        n_shift = 0;
      end else begin
        check("idle_cset", cset, m_cset);
      end
`ifndef CFG_CHECKSUM_EN
      check("err_tied", err, 0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_load(input int gap_len, input bit start_mid, input int abort_bit,
                          input logic [7:0] csum, output int lat);
    int k, hs, budget, nhs;
    bit gap_done, mid_done;
    lat = -1; k = 0; hs = -1; budget = 0; gap_done = 0; mid_done = 0;
`ifdef CFG_CHECKSUM_EN
    nhs = NWORDS + 1;
    exp_good = (csum == model_sum());
`else
    nhs = NWORDS;
    exp_good = 1'b1;
`endif
    exp_q.delete();
    for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(words[i / WORD_W][i % WORD_W]);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_cset_low", cset, 0);

    s_data  = words[0];
    s_valid = 1'b1;
    while (k < nhs && budget < 600) begin
      if (abort_bit >= 0 && n_shift >= abort_bit) break;
      if (gap_len > 0 && k == 2 && !gap_done && s_ready) begin
        s_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_no_shift", cfg_shift, 0);
          check("gap_ready", s_ready, 1);
        end
        gap_done = 1;
        s_valid  = 1'b1;
      end else if (s_ready && s_valid) begin
        if (hs < 0) hs = cyc;
        k++;
        tick();
        if (k < NWORDS) s_data = words[k];
        else            s_data = csum;
      end else if (start_mid && k == 3 && !mid_done) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        mid_done = 1;
      end else begin
        tick();
      end
      budget++;
    end
    s_valid = 1'b0;

    if (abort_bit >= 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_cset", cset, 0);
      check("rst_mid_shift", cfg_shift, 0);
      check("rst_mid_ready", s_ready, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_err", err, 0);
      exp_q.delete();
      lat = 0;
      return;
    end

    if (k < nhs) check("handshake_timeout", k, nhs);
    budget = 0;
    while (!done && budget < 100) begin
      tick();
      budget++;
    end
    check("done_seen", done, 1);
    lat = (hs >= 0) ? (cyc - hs) : -1;
    tick();
    check("done_one_cycle", done, 0);
    check("after_done_busy", busy, 0);
    check("after_done_cset", cset, exp_good);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    logic [7:0] cs;
    cs = 8'h00;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_cset", cset, 0);
    check("rst_shift", cfg_shift, 0);
    check("rst_ready", s_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_sout", cfg_sout, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", s_ready, 0);
    check("idle_busy", busy, 0);

    // continuous stream
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h0F};
`ifdef CFG_CHECKSUM_EN
    check("sum_model_pin", model_sum(), 8'h70);
    cs = model_sum();
`endif
    run_load(0, 0, -1, cs, lat);
    check("cont_latency", lat, LAT);
    check("cont_chain", cap, 44'hF8100FF3CA5);

    // 7-cycle source stall between the second and third words
    cap = '0;
    run_load(7, 0, -1, cs, lat);
    check("gap_latency", lat, LAT + 7);
    check("gap_chain", cap, 44'hF8100FF3CA5);

    // start pulsed while shifting is ignored
    cap = '0;
    run_load(0, 1, -1, cs, lat);
    check("restart_latency", lat, LAT);
    check("restart_chain", cap, 44'hF8100FF3CA5);

    // reset at bit 20, then a clean reload
    run_load(0, 0, 20, cs, lat);
    cap = '0;
    run_load(0, 0, -1, cs, lat);
    check("reload_latency", lat, LAT);
    check("reload_chain", cap, 44'hF8100FF3CA5);

    // back-to-back: the next start lands on the cycle after done
    words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
`ifdef CFG_CHECKSUM_EN
    check("sum_model_pin2", model_sum(), 8'h6A);
    cs = model_sum();
`endif
    cap = '0;
    run_load(0, 0, -1, cs, lat);
    check("b2b_latency", lat, LAT);
    check("b2b_chain", cap, 44'hC9A78563412);

`ifdef CFG_CHECKSUM_EN
    // wrong checksum: err set, done pulses, cset stays low
    words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h0F};
    run_load(0, 0, -1, 8'h71, lat);
    check("bad_sum_latency", lat, LAT);
    check("bad_sum_err_sticky", err, 1);
    check("bad_sum_cset", cset, 0);
    run_load(0, 0, -1, 8'h70, lat);
    check("good_sum_err", err, 0);
    check("good_sum_cset", cset, 1);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
